// File: rtl/cpu_pkg.sv
// cpu_pkg: shared widths and the writeback queue entry type
//   XLEN       - datapath width
//   REG_ADDR_W - register address width
//   WB_DEPTH   - default writeback queue depth
//   wb_entry_t - one queued result {rd, data}
package cpu_pkg;
    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;
    localparam int WB_DEPTH   = 4;
    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic [XLEN-1:0]       data;
    } wb_entry_t;
endpackage

// File: rtl/wb_bypass_cam.sv
// wb_bypass_cam: one bypass lookup over the queued entries, youngest match wins
//   i_ent  - queued entries in age order (index 0 oldest)
//   i_vld  - per-entry occupied flag, same order
//   i_rs   - lookup register address (0 never hits)
//   o_hit  - some occupied entry matches i_rs
//   o_data - data of the youngest matching entry, 0 on miss
module wb_bypass_cam import cpu_pkg::*; #(
    parameter int N = WB_DEPTH
) (
    input  wb_entry_t [N-1:0]        i_ent,
    input  logic [N-1:0]             i_vld,
    input  logic [REG_ADDR_W-1:0]    i_rs,
    output logic                     o_hit,
    output logic [XLEN-1:0]          o_data
);
    // Scan oldest to youngest so a later (younger) match overrides an earlier one.
    always_comb begin
        o_hit  = 1'b0;
        o_data = '0;
        for (int i = 0; i < N; i++) begin
            if (i_vld[i] && i_rs != '0 && i_ent[i].rd == i_rs) begin
                o_hit  = 1'b1;
                o_data = i_ent[i].data;
            end
        end
    end
endmodule

// File: rtl/wb_queue.sv
// wb_queue: dual-issue writeback queue draining up to two results per cycle
//   clk, rst                 - clock, synchronous active-high reset
//   in_valid0/rd0/data0      - older incoming result
//   in_valid1/rd1/data1      - younger incoming result (ignored unless slot0 valid)
//   in_ready                 - at least two free entries
//   wb_stall                 - hold draining
//   rd1/wb_data1/wb_we1      - register file write port 1 (oldest entry)
//   rd2/wb_data2/wb_we2      - register file write port 2 (second oldest entry)
//   count/empty/full         - occupancy
//   byp_rs0..3, byp_hit, byp_data0..3 - bypass lookups, active with WB_BYPASS_EN
module wb_queue #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid0,
    input  logic [4:0]      in_rd0,
    input  logic [XLEN-1:0] in_data0,
    input  logic            in_valid1,
    input  logic [4:0]      in_rd1,
    input  logic [XLEN-1:0] in_data1,
    output logic            in_ready,
    input  logic            wb_stall,
    output logic [4:0]      rd1,
    output logic [XLEN-1:0] wb_data1,
    output logic            wb_we1,
    output logic [4:0]      rd2,
    output logic [XLEN-1:0] wb_data2,
    output logic            wb_we2,
    output logic [2:0]      count,
    output logic            empty,
    output logic            full,
    input  logic [4:0]      byp_rs0,
    input  logic [4:0]      byp_rs1,
    input  logic [4:0]      byp_rs2,
    input  logic [4:0]      byp_rs3,
    output logic [3:0]      byp_hit,
    output logic [XLEN-1:0] byp_data0,
    output logic [XLEN-1:0] byp_data1,
    output logic [XLEN-1:0] byp_data2,
    output logic [XLEN-1:0] byp_data3
);
    import cpu_pkg::*;
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    wb_entry_t       r_mem [DEPTH];
    logic [AW-1:0]   r_head;
    logic [AW-1:0]   r_tail;
    logic [CW-1:0]   r_count;
    logic [AW-1:0]   w_h1;
    logic [AW-1:0]   w_t1;
    wb_entry_t       w_e1;
    wb_entry_t       w_e2;
    logic            w_c1;
    logic            w_c2;
    logic            w_enq0;
    logic            w_enq1;
    logic [CW-1:0]   w_nenq;
    logic [CW-1:0]   w_deq;
    assign w_h1     = r_head + AW'(1);
    assign w_t1     = r_tail + AW'(1);
    assign w_e1     = r_mem[r_head];
    assign w_e2     = r_mem[w_h1];
    assign w_c1     = r_count >= CW'(1);
    assign w_c2     = r_count >= CW'(2);
    // Readiness looks only at current occupancy, not this cycle's drain.
    assign in_ready = r_count <= CW'(DEPTH - 2);
    assign w_enq0   = in_ready && in_valid0;
    assign w_enq1   = w_enq0 && in_valid1;
    assign w_nenq   = w_enq1 ? CW'(2) : CW'(w_enq0);
    assign w_deq    = wb_stall ? '0 : (w_c2 ? CW'(2) : r_count);
    assign rd1      = w_e1.rd;
    assign wb_data1 = w_e1.data;
    assign rd2      = w_e2.rd;
    assign wb_data2 = w_e2.data;
    // Port 1 yields to port 2 on a same-register pair so the younger value lands.
    assign wb_we1   = !rst && !wb_stall && w_c1 && w_e1.rd != '0 && !(w_c2 && w_e1.rd == w_e2.rd);
    assign wb_we2   = !rst && !wb_stall && w_c2 && w_e2.rd != '0;
    assign count    = 3'(r_count);
    assign empty    = r_count == '0;
    assign full     = r_count == CW'(DEPTH);
    always_ff @(posedge clk) begin
        if (rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            r_tail  <= r_tail + AW'(w_nenq);
            r_head  <= r_head + AW'(w_deq);
            r_count <= r_count + w_nenq - w_deq;
        end
    end
    // Storage is never cleared; occupancy alone decides what is live.
    always_ff @(posedge clk) begin
        if (w_enq0) r_mem[r_tail] <= '{rd: in_rd0, data: in_data0};
        if (w_enq1) r_mem[w_t1]   <= '{rd: in_rd1, data: in_data1};
    end
`ifdef WB_BYPASS_EN
    wb_entry_t [DEPTH-1:0] w_age;
    logic [DEPTH-1:0]      w_vld;
    logic [4:0]            w_rs [4];
    logic [XLEN-1:0]       w_bd [4];
    logic [3:0]            w_hit;
    assign w_rs = '{byp_rs0, byp_rs1, byp_rs2, byp_rs3};
    // Rotate storage into age order so the CAM can apply youngest-wins priority.
    for (genvar i = 0; i < DEPTH; i++) begin : g_age
        assign w_age[i] = r_mem[r_head + AW'(i)];
        assign w_vld[i] = CW'(i) < r_count;
    end
    for (genvar k = 0; k < 4; k++) begin : g_cam
        wb_bypass_cam #(.N(DEPTH)) u_cam (
            .i_ent  (w_age),
            .i_vld  (w_vld),
            .i_rs   (w_rs[k]),
            .o_hit  (w_hit[k]),
            .o_data (w_bd[k])
        );
    end
    assign byp_hit   = rst ? 4'b0 : w_hit;
    assign byp_data0 = w_bd[0];
    assign byp_data1 = w_bd[1];
    assign byp_data2 = w_bd[2];
    assign byp_data3 = w_bd[3];
`else
    logic w_unused;
    assign w_unused  = ^{byp_rs0, byp_rs1, byp_rs2, byp_rs3};
    assign byp_hit   = '0;
    assign byp_data0 = '0;
    assign byp_data1 = '0;
    assign byp_data2 = '0;
    assign byp_data3 = '0;
`endif
endmodule

// File: tb/tb_wb_queue.sv
// tb_wb_queue: directed self-checking bench for wb_queue
module tb_wb_queue;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid0, in_valid1, in_ready, wb_stall;
    logic [4:0]  in_rd0, in_rd1, rd1, rd2;
    logic [31:0] in_data0, in_data1, wb_data1, wb_data2;
    logic        wb_we1, wb_we2, empty, full;
    logic [2:0]  count;
    logic [4:0]  byp_rs0, byp_rs1, byp_rs2, byp_rs3;
    logic [3:0]  byp_hit;
    logic [31:0] byp_data0, byp_data1, byp_data2, byp_data3;
    int          total = 0;
    int          fails = 0;

    always #5 clk = ~clk;

    wb_queue #(.XLEN(32), .DEPTH(4)) dut (
        .clk(clk), .rst(rst),
        .in_valid0(in_valid0), .in_rd0(in_rd0), .in_data0(in_data0),
        .in_valid1(in_valid1), .in_rd1(in_rd1), .in_data1(in_data1),
        .in_ready(in_ready), .wb_stall(wb_stall),
        .rd1(rd1), .wb_data1(wb_data1), .wb_we1(wb_we1),
        .rd2(rd2), .wb_data2(wb_data2), .wb_we2(wb_we2),
        .count(count), .empty(empty), .full(full),
        .byp_rs0(byp_rs0), .byp_rs1(byp_rs1), .byp_rs2(byp_rs2), .byp_rs3(byp_rs3),
        .byp_hit(byp_hit),
        .byp_data0(byp_data0), .byp_data1(byp_data1), .byp_data2(byp_data2), .byp_data3(byp_data3)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic v0, input logic [4:0] r0, input logic [31:0] d0,
                        input logic v1, input logic [4:0] r1, input logic [31:0] d1);
        in_valid0 = v0; in_rd0 = r0; in_data0 = d0;
        in_valid1 = v1; in_rd1 = r1; in_data1 = d1;
    endtask

    initial begin
        rst = 1'b1; wb_stall = 1'b0;
        push(0, 0, 0, 0, 0, 0);
        byp_rs0 = 0; byp_rs1 = 0; byp_rs2 = 0; byp_rs3 = 0;
        tick; tick;
        rst = 1'b0;
        chk("rst_count", 32'(count), 0);
        chk("rst_empty", 32'(empty), 1);
        chk("rst_full", 32'(full), 0);
        chk("rst_ready", 32'(in_ready), 1);
        chk("rst_we1", 32'(wb_we1), 0);
        chk("rst_we2", 32'(wb_we2), 0);
        chk("rst_hit", 32'(byp_hit), 0);

        push(1, 5, 32'h11, 1, 6, 32'h22);
        tick;
        push(0, 0, 0, 0, 0, 0);
        chk("pair_count", 32'(count), 2);
        chk("pair_rd1", 32'(rd1), 5);
        chk("pair_we1", 32'(wb_we1), 1);
        chk("pair_d1", wb_data1, 32'h11);
        chk("pair_rd2", 32'(rd2), 6);
        chk("pair_we2", 32'(wb_we2), 1);
        chk("pair_d2", wb_data2, 32'h22);
        tick;
        chk("pair_drained", 32'(count), 0);
        chk("pair_we1_off", 32'(wb_we1), 0);

        push(1, 7, 32'hA, 1, 7, 32'hB);
        tick;
        push(0, 0, 0, 0, 0, 0);
        chk("same_we1", 32'(wb_we1), 0);
        chk("same_we2", 32'(wb_we2), 1);
        chk("same_rd2", 32'(rd2), 7);
        chk("same_d2", wb_data2, 32'hB);
        tick;
        chk("same_drained", 32'(count), 0);

        wb_stall = 1'b1;
        push(1, 1, 32'h101, 1, 2, 32'h102);
        tick;
        chk("stall_cnt2", 32'(count), 2);
        chk("stall_ready2", 32'(in_ready), 1);
        chk("stall_we1", 32'(wb_we1), 0);
        chk("stall_we2", 32'(wb_we2), 0);
        push(1, 3, 32'h103, 1, 4, 32'h104);
        tick;
        chk("stall_cnt4", 32'(count), 4);
        chk("stall_full", 32'(full), 1);
        chk("stall_notready", 32'(in_ready), 0);
        push(1, 8, 32'h108, 1, 9, 32'h109);
        tick;
        chk("third_ignored", 32'(count), 4);
        push(0, 0, 0, 0, 0, 0);
        wb_stall = 1'b0;
        #1;
        chk("rel_rd1", 32'(rd1), 1);
        chk("rel_we1", 32'(wb_we1), 1);
        chk("rel_rd2", 32'(rd2), 2);
        tick;
        chk("rel_cnt2", 32'(count), 2);
        chk("rel_rd1b", 32'(rd1), 3);
        chk("rel_d1b", wb_data1, 32'h103);
        chk("rel_rd2b", 32'(rd2), 4);
        tick;
        chk("rel_empty", 32'(empty), 1);

        push(0, 0, 0, 1, 10, 32'h10);
        tick;
        chk("v1_only_ignored", 32'(count), 0);
        push(1, 0, 32'hFF, 0, 0, 0);
        tick;
        push(0, 0, 0, 0, 0, 0);
        chk("r0_count", 32'(count), 1);
        chk("r0_d1", wb_data1, 32'hFF);
        chk("r0_we1", 32'(wb_we1), 0);
        chk("r0_we2", 32'(wb_we2), 0);
        tick;
        chk("r0_retired", 32'(count), 0);

        wb_stall = 1'b1;
        push(1, 3, 32'h1, 0, 0, 0);
        tick;
        push(1, 3, 32'h2, 0, 0, 0);
        tick;
        push(0, 0, 0, 0, 0, 0);
        byp_rs0 = 3; byp_rs1 = 0; byp_rs2 = 9;
        #1;
`ifdef WB_BYPASS_EN
        chk("byp_hit0", 32'(byp_hit[0]), 1);
        chk("byp_data0", byp_data0, 32'h2);
        chk("byp_hit1", 32'(byp_hit[1]), 0);
        chk("byp_hit2", 32'(byp_hit[2]), 0);
`else
        chk("byp_off_hit", 32'(byp_hit), 0);
        chk("byp_off_data0", byp_data0, 0);
`endif
        push(1, 5, 32'h55, 0, 0, 0);
        tick;
        push(0, 0, 0, 0, 0, 0);
        chk("pre_rst_cnt", 32'(count), 3);
        rst = 1'b1; wb_stall = 1'b0;
        #1;
        chk("rstcyc_we1", 32'(wb_we1), 0);
        chk("rstcyc_we2", 32'(wb_we2), 0);
        tick;
        rst = 1'b0;
        chk("midrst_cnt", 32'(count), 0);
        chk("midrst_ready", 32'(in_ready), 1);
        chk("midrst_we1", 32'(wb_we1), 0);
        chk("midrst_we2", 32'(wb_we2), 0);

        for (int i = 0; i < 10; i++) begin
            push(1, 5'(i + 1), 32'h1000 + 32'(2 * i), 1, 5'(i + 11), 32'h1001 + 32'(2 * i));
            tick;
            chk("wrap_cnt", 32'(count), 2);
            chk("wrap_rd1", 32'(rd1), 32'(i + 1));
            chk("wrap_d1", wb_data1, 32'h1000 + 32'(2 * i));
            chk("wrap_d2", wb_data2, 32'h1001 + 32'(2 * i));
        end
        push(0, 0, 0, 0, 0, 0);
        tick;
        chk("wrap_empty", 32'(empty), 1);

        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end
endmodule

// File: doc/wb_queue.md
WB_QUEUE -- requirements
Module: wb_queue

Interface
REQ-001 Parameters SHALL be: XLEN, 32, data width; DEPTH, 4, queue entries (power of two, >=2).
REQ-002 Ports SHALL be:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
in_valid0  in  1  slot0 (older) result valid
in_rd0  in  5  slot0 destination
in_data0  in  XLEN  slot0 result
in_valid1  in  1  slot1 (younger) result valid
in_rd1  in  5  slot1 destination
in_data1  in  XLEN  slot1 result
in_ready  out  1  >=2 free entries
wb_stall  in  1  hold draining
rd1  out  5  write port 1 address
wb_data1  out  XLEN  write port 1 data
wb_we1  out  1  write port 1 enable
rd2  out  5  write port 2 address
wb_data2  out  XLEN  write port 2 data
wb_we2  out  1  write port 2 enable
count  out  3  occupied entries
empty  out  1  count==0
full  out  1  count==DEPTH
byp_rs0..byp_rs3  in  5 each  bypass lookup addresses
byp_hit  out  4  per-lookup hit
byp_data0..byp_data3  out  XLEN each  per-lookup forwarded value

Function
REQ-003 Queue SHALL be a circular buffer; head/tail pointers wrap modulo DEPTH.
REQ-004 Enqueue SHALL occur only when in_ready=1; in_ready=1 iff free entries (before this cycle's drain) >=2.
REQ-005 With in_valid0=1, in_valid1=1: slot0 written at tail, slot1 at tail+1, tail+=2.
REQ-006 With only in_valid0=1: one entry enqueued; in_valid1 SHALL be ignored whenever in_valid0=0.
REQ-007 Results with rd=0 SHALL still be enqueued (preserve ordering) but never drive a write enable.
REQ-008 Write ports SHALL be driven combinationally from storage: port1 = head entry, port2 = head+1 entry.
REQ-009 When wb_stall=0: retire min(count,2) entries per cycle; wb_we1=(count>=1 && rd1!=0), wb_we2=(count>=2 && rd2!=0).
REQ-010 When wb_stall=1: no retire; wb_we1=wb_we2=0; enqueue still permitted.
REQ-011 If both retiring entries have equal nonzero rd, wb_we1 SHALL be 0 (younger port2 value wins); both entries still retire.
REQ-012 Latency: entry enqueued at edge N SHALL appear on a write port in cycle N+1 and retire at edge N+1 if wb_stall=0 and it is among the two oldest.
REQ-013 Simultaneous enqueue and retire SHALL be allowed; count_next = count + enq - deq.
REQ-014 rd/wb_data outputs for unoccupied slots SHALL be don't-care with enable 0.

Reset
REQ-015 On rst: head=tail=0, count=0, empty=1, full=0, in_ready=1, wb_we1=wb_we2=0, byp_hit=0; stored data not cleared.
REQ-016 rst mid-operation SHALL discard all queued entries with no write enable asserted in the reset cycle.

Configuration
REQ-017 Macro WB_BYPASS_EN defined: for each lookup k, byp_hit[k]=1 iff byp_rs_k!=0 and a queued entry has rd==byp_rs_k; byp_data_k = youngest matching entry's data; same-cycle inputs not searched.
REQ-018 WB_BYPASS_EN undefined: byp_hit=0, byp_data0..3=0, no match logic synthesized; ports retained.

Structure
REQ-019 Shared package cpu_pkg SHALL hold XLEN, REG_ADDR_W=5, WB_DEPTH and typedef wb_entry_t {rd, data}.
REQ-020 Bypass match SHALL be sub-module wb_bypass_cam (one lookup, age-priority youngest match), instantiated 4x under WB_BYPASS_EN.

Verification
REQ-021 Reset, then enqueue slot0 (rd=5, 0x11), slot1 (rd=6, 0x22) -> next cycle rd1=5/wb_we1=1, rd2=6/wb_we2=1; count 2->0.
REQ-022 Same-rd pair (rd=7, 0xA then 0xB) -> wb_we1=0, wb_we2=1, wb_data2=0xB.
REQ-023 wb_stall=1, enqueue 2 pairs -> count=4, full=1, in_ready=0; third pair ignored; release stall -> 2 retire/cycle, empty after 2 cycles.
REQ-024 Enqueue rd=0 data 0xFF -> retires with wb_we1=0, count decrements.
REQ-025 WB_BYPASS_EN, stall, queue rd=3:0x1 then rd=3:0x2, byp_rs0=3 -> byp_hit[0]=1, byp_data0=0x2; byp_rs1=0 -> hit 0.
REQ-026 rst asserted with count=3 -> next cycle count=0, wb_we1=wb_we2=0, in_ready=1; pointer wrap verified over 10 pairs.
